regfile_scb: RTL and testbench
==============================

Name: regfile_scb

Overview:
- Parametrised successor to the 32x32 register file: configurable width and depth, register 0 hardwired to zero (selectable), two combinational read ports, one write port.
- Adds a per-register pending scoreboard. Bits are set when an instruction targeting the register issues and cleared at writeback, so the decode stage detects RAW hazards.
- Adds a sequential bulk-clear engine that zeroes every register and pending bit, one register per cycle, on request.
- Sits between decode (read/issue) and writeback (write) in the pipeline.

Parameters:
- DATA_W, 32, register width in bits
- ADDR_W, 5, address width; DEPTH = 2**ADDR_W registers
- ZERO_REG, 1, when 1 register 0 reads 0, ignores writes and never goes pending

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous active-high reset
- wr_en  in  1  writeback enable
- wr_addr  in  ADDR_W  writeback register index
- wr_data  in  DATA_W  writeback data
- iss_en  in  1  issue: mark iss_addr pending
- iss_addr  in  ADDR_W  destination of issuing instruction
- rd_addr1  in  ADDR_W  read port 1 index
- rd_addr2  in  ADDR_W  read port 2 index
- rd_data1  out  DATA_W  read port 1 data (combinational)
- rd_data2  out  DATA_W  read port 2 data (combinational)
- rd_pend1  out  1  pending flag of rd_addr1 (combinational)
- rd_pend2  out  1  pending flag of rd_addr2 (combinational)
- clr_req  in  1  start bulk clear (sampled in IDLE only)
- clr_busy  out  1  high while clear in progress
- clr_done  out  1  one-cycle pulse when clear completes

Behaviour:
- Reset (async, rst=1): all registers 0; all pending bits 0; FSM in IDLE; clear counter 0; clr_busy=0; clr_done=0. Reads during reset return 0.
- Write: on a clk edge with wr_en=1 and FSM in IDLE, regs[wr_addr] <= wr_data and pend[wr_addr] <= 0. Latency is one cycle; the new value is visible on the read ports after the edge.
- Issue: on a clk edge with iss_en=1 in IDLE, pend[iss_addr] <= 1.
- Same-cycle write and issue to the same address: data is written and pend ends at 1 (the issue is a newer producer, so issue wins).
- ZERO_REG=1 with address 0: writes and issues are ignored; rd_data=0 and rd_pend=0 whenever the read address is 0.
- Reads are asynchronous: rd_dataN = regs[rd_addrN] and rd_pendN = pend[rd_addrN], with no clock latency.
- Clear FSM states:
  - IDLE: clr_req=1 -> CLEAR, counter <= 0.
  - CLEAR: each cycle regs[counter] <= 0, pend[counter] <= 0, counter++. When counter == DEPTH-1, go to DONE.
  - DONE: clr_done=1 for one cycle -> IDLE.
- clr_busy=1 in CLEAR and DONE.
- Total clear latency is DEPTH+1 cycles from acceptance to return to IDLE; DEPTH=32 gives 33 cycles.
- While clr_busy=1: wr_en, iss_en and clr_req are ignored (dropped, not queued). Reads continue and return the current, partially cleared contents.
- Counter wrap: the counter is ADDR_W bits. The terminal compare with DEPTH-1 prevents wrap; the counter holds at 0 outside CLEAR.
- rst asserted mid-clear aborts immediately to the reset state. No clr_done pulse is produced.

Optional Feature:
- Macro: REGFILE_SCB_BYPASS_EN
- Defined: write-through forwarding. When wr_en=1 in IDLE and rd_addrN == wr_addr (and not hardwired register 0), rd_dataN = wr_data and rd_pendN = 0 in the same cycle, unless iss_en targets the same address that cycle, in which case rd_pendN = 1.
- Not defined: reads return the pre-edge register and pending contents; the new value appears the cycle after the write.

Decomposition:
- Shared package regfile_scb_pkg holds:
  - the clear FSM state enum (ST_IDLE, ST_CLEAR, ST_DONE)
  - default width/address constants
  - the ZERO_REG index constant 0
- One natural sub-module, regfile_scb_clr_fsm: state register plus counter. Outputs clr_wr_en, clr_addr, clr_busy and clr_done; the top muxes the clear write into the array.

Test Plan:
- Reset then read all addresses -> rd_data=0 and rd_pend=0 for every register; clr_busy=0.
- Write 0xDEADBEEF to r5, read r5 next cycle -> 0xDEADBEEF; write 0x1234 to r0 -> r0 still reads 0.
- Issue r7, then read -> rd_pend=1. Same cycle: write r7=0xA5 with iss r7 -> after edge pend=1 and data=0xA5. Later write-only r7 -> pend=0.
- Load r1..r31 with nonzero values, pulse clr_req -> clr_busy high 33 cycles, clr_done pulses on cycle 33, all registers 0. A write to r3 issued mid-clear is dropped (r3 stays 0).
- Assert rst at clear cycle 10 -> FSM to IDLE, no clr_done, all registers 0.
- With REGFILE_SCB_BYPASS_EN: wr r9=0x55 and rd_addr1=9 in the same cycle -> rd_data1=0x55 combinationally. Without the macro -> old value, 0x55 the next cycle.

Source files
------------

// File: rtl/regfile_scb_pkg.sv
// Shared types and constants for the scoreboarded register file.
// Consumed by regfile_scb (top) and regfile_scb_clr_fsm.
package regfile_scb_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 5;
    localparam int ZERO_IDX   = 0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_DONE  = 2'd2
    } clr_state_e;

endpackage

// File: rtl/regfile_scb_clr_fsm.sv
// Bulk-clear sequencer: walks every register index once, then pulses clr_done.
// All outputs are registered; clr_busy covers both the CLEAR and DONE states.
module regfile_scb_clr_fsm
    import regfile_scb_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr_req,
    output logic              clr_wr_en,
    output logic [ADDR_W-1:0] clr_addr,
    output logic              clr_busy,
    output logic              clr_done
);

    localparam logic [ADDR_W-1:0] LAST_IDX = {ADDR_W{1'b1}};

    clr_state_e        state_q;
    logic [ADDR_W-1:0] cnt_q;
    logic              wr_en_q;
    logic              busy_q;
    logic              done_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            wr_en_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    cnt_q <= '0;
                    if (clr_req) begin
                        state_q <= ST_CLEAR;
                        wr_en_q <= 1'b1;
                        busy_q  <= 1'b1;
                    end
                end
                ST_CLEAR: begin
                    // Terminal compare stops the counter before it can wrap.
                    if (cnt_q == LAST_IDX) begin
                        state_q <= ST_DONE;
                        cnt_q   <= '0;
                        wr_en_q <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                    cnt_q   <= '0;
                    wr_en_q <= 1'b0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign clr_wr_en = wr_en_q;
    assign clr_addr  = cnt_q;
    assign clr_busy  = busy_q;
    assign clr_done  = done_q;

endmodule

// File: rtl/regfile_scb.sv
// Parametrised register file with per-register pending scoreboard and bulk clear.
// Optional write-through forwarding to the read ports: define REGFILE_SCB_BYPASS_EN.
module regfile_scb
    import regfile_scb_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              iss_en,
    input  logic [ADDR_W-1:0] iss_addr,
    input  logic [ADDR_W-1:0] rd_addr1,
    input  logic [ADDR_W-1:0] rd_addr2,
    output logic [DATA_W-1:0] rd_data1,
    output logic [DATA_W-1:0] rd_data2,
    output logic              rd_pend1,
    output logic              rd_pend2,
    input  logic              clr_req,
    output logic              clr_busy,
    output logic              clr_done
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic              clr_wr_en;
    logic [ADDR_W-1:0] clr_addr;
    logic              host_wr;
    logic              host_iss;
    logic [DATA_W-1:0] regs_rd [DEPTH];
    logic              pend_rd [DEPTH];

    regfile_scb_clr_fsm #(
        .ADDR_W (ADDR_W)
    ) u_clr_fsm (
        .clk       (clk),
        .rst       (rst),
        .clr_req   (clr_req),
        .clr_wr_en (clr_wr_en),
        .clr_addr  (clr_addr),
        .clr_busy  (clr_busy),
        .clr_done  (clr_done)
    );

    // Decode-side traffic is dropped outright while a clear is running.
    assign host_wr  = wr_en  && !clr_busy;
    assign host_iss = iss_en && !clr_busy;

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_reg
        if (ZERO_REG != 0 && gi == ZERO_IDX) begin : g_hardwired
            assign regs_rd[gi] = '0;
            assign pend_rd[gi] = 1'b0;
        end else begin : g_store
            logic [DATA_W-1:0] data_d;
            logic [DATA_W-1:0] data_q;
            logic              pend_d;
            logic              pend_q;

            always_comb begin
                data_d = data_q;
                pend_d = pend_q;
                if (clr_wr_en && clr_addr == ADDR_W'(gi)) begin
                    data_d = '0;
                    pend_d = 1'b0;
                end else begin
                    if (host_wr && wr_addr == ADDR_W'(gi)) begin
                        data_d = wr_data;
                        pend_d = 1'b0;
                    end
                    // A same-cycle issue is the newer producer, so it overrides writeback.
                    if (host_iss && iss_addr == ADDR_W'(gi)) begin
                        pend_d = 1'b1;
                    end
                end
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    data_q <= '0;
                    pend_q <= 1'b0;
                end else begin
                    data_q <= data_d;
                    pend_q <= pend_d;
                end
            end

            assign regs_rd[gi] = data_q;
            assign pend_rd[gi] = pend_q;
        end
    end

`ifdef REGFILE_SCB_BYPASS_EN
    logic wr_fwd_ok;
    logic wr_fwd_pend;

    assign wr_fwd_ok   = host_wr && !(ZERO_REG != 0 && wr_addr == ADDR_W'(ZERO_IDX));
    assign wr_fwd_pend = host_iss && (iss_addr == wr_addr);

    always_comb begin
        rd_data1 = regs_rd[rd_addr1];
        rd_pend1 = pend_rd[rd_addr1];
        rd_data2 = regs_rd[rd_addr2];
        rd_pend2 = pend_rd[rd_addr2];
        if (wr_fwd_ok && rd_addr1 == wr_addr) begin
            rd_data1 = wr_data;
            rd_pend1 = wr_fwd_pend;
        end
        if (wr_fwd_ok && rd_addr2 == wr_addr) begin
            rd_data2 = wr_data;
            rd_pend2 = wr_fwd_pend;
        end
    end
`else
    always_comb begin
        rd_data1 = regs_rd[rd_addr1];
        rd_pend1 = pend_rd[rd_addr1];
        rd_data2 = regs_rd[rd_addr2];
        rd_pend2 = pend_rd[rd_addr2];
    end
`endif

endmodule

// File: tb/tb_regfile_scb.sv
// Directed, table-driven bench for regfile_scb (default 32x32, ZERO_REG=1).
module tb_regfile_scb;

    logic        clk;
    logic        rst;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic        iss_en;
    logic [4:0]  iss_addr;
    logic [4:0]  rd_addr1;
    logic [4:0]  rd_addr2;
    logic [31:0] rd_data1;
    logic [31:0] rd_data2;
    logic        rd_pend1;
    logic        rd_pend2;
    logic        clr_req;
    logic        clr_busy;
    logic        clr_done;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic        ie;
        logic [4:0]  ia;
        logic [4:0]  ra1;
        logic [4:0]  ra2;
        logic [31:0] d1;
        logic        p1;
        logic [31:0] d2;
        logic        p2;
    } vec_t;

    vec_t vecs [9];

    regfile_scb dut (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .iss_en   (iss_en),
        .iss_addr (iss_addr),
        .rd_addr1 (rd_addr1),
        .rd_addr2 (rd_addr2),
        .rd_data1 (rd_data1),
        .rd_data2 (rd_data2),
        .rd_pend1 (rd_pend1),
        .rd_pend2 (rd_pend2),
        .clr_req  (clr_req),
        .clr_busy (clr_busy),
        .clr_done (clr_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d]: got %h expected %h", name, idx, act, exp);
        end
    endtask

    task automatic check_all_zero(input string name);
        for (int a = 0; a < 32; a++) begin
            rd_addr1 = 5'(a);
            rd_addr2 = 5'(31 - a);
            #1;
            chk({name, "_d1"}, a, rd_data1, 32'h0);
            chk({name, "_p1"}, a, {31'h0, rd_pend1}, 32'h0);
            chk({name, "_d2"}, a, rd_data2, 32'h0);
            chk({name, "_p2"}, a, {31'h0, rd_pend2}, 32'h0);
        end
    endtask

    initial begin
        logic saw_done;

        rst = 1'b1; wr_en = 0; wr_addr = 0; wr_data = 0;
        iss_en = 0; iss_addr = 0; rd_addr1 = 0; rd_addr2 = 0; clr_req = 0;

        //                we  wa  wd             ie  ia  ra1 ra2 d1             p1  d2             p2
        vecs[0] = '{1'b1, 5,  32'hDEADBEEF, 1'b0, 0,  5,  0,  32'hDEADBEEF, 1'b0, 32'h0,        1'b0};
        vecs[1] = '{1'b1, 0,  32'h00001234, 1'b0, 0,  0,  5,  32'h0,        1'b0, 32'hDEADBEEF, 1'b0};
        vecs[2] = '{1'b0, 0,  32'h0,        1'b1, 7,  7,  5,  32'h0,        1'b1, 32'hDEADBEEF, 1'b0};
        vecs[3] = '{1'b1, 7,  32'h000000A5, 1'b1, 7,  7,  0,  32'h000000A5, 1'b1, 32'h0,        1'b0};
        vecs[4] = '{1'b1, 7,  32'h00000077, 1'b0, 0,  7,  5,  32'h00000077, 1'b0, 32'hDEADBEEF, 1'b0};
        vecs[5] = '{1'b0, 0,  32'h0,        1'b1, 0,  0,  7,  32'h0,        1'b0, 32'h00000077, 1'b0};
        vecs[6] = '{1'b1, 31, 32'hFFFFFFFF, 1'b1, 30, 31, 30, 32'hFFFFFFFF, 1'b0, 32'h0,        1'b1};
        vecs[7] = '{1'b1, 30, 32'h00000030, 1'b0, 0,  30, 31, 32'h00000030, 1'b0, 32'hFFFFFFFF, 1'b0};
        vecs[8] = '{1'b1, 2,  32'h00000022, 1'b1, 1,  1,  2,  32'h0,        1'b1, 32'h00000022, 1'b0};

        // Reset state, sampled while rst is still asserted.
        repeat (2) @(negedge clk);
        #1;
        chk("rst_busy", 0, {31'h0, clr_busy}, 32'h0);
        chk("rst_done", 0, {31'h0, clr_done}, 32'h0);
        check_all_zero("rst");
        @(negedge clk);
        rst = 1'b0;

        // Table-driven single-cycle transactions; reads observed after the edge.
        for (int v = 0; v < 9; v++) begin
            @(negedge clk);
            wr_en = vecs[v].we; wr_addr = vecs[v].wa; wr_data = vecs[v].wd;
            iss_en = vecs[v].ie; iss_addr = vecs[v].ia;
            rd_addr1 = vecs[v].ra1; rd_addr2 = vecs[v].ra2;
            @(negedge clk);
            wr_en = 1'b0; iss_en = 1'b0;
            #1;
            $display("vec %0d: wr=%0b a=%0d d=%h iss=%0b a=%0d | rd1[%0d]=%h/%0b rd2[%0d]=%h/%0b",
                     v, vecs[v].we, vecs[v].wa, vecs[v].wd, vecs[v].ie, vecs[v].ia,
                     vecs[v].ra1, rd_data1, rd_pend1, vecs[v].ra2, rd_data2, rd_pend2);
            chk("vec_d1", v, rd_data1, vecs[v].d1);
            chk("vec_p1", v, {31'h0, rd_pend1}, {31'h0, vecs[v].p1});
            chk("vec_d2", v, rd_data2, vecs[v].d2);
            chk("vec_p2", v, {31'h0, rd_pend2}, {31'h0, vecs[v].p2});
        end

        // Same-cycle visibility of a write to r9 (previously zero).
        @(negedge clk);
        wr_en = 1'b1; wr_addr = 9; wr_data = 32'h55; rd_addr1 = 9;
        #1;
`ifdef REGFILE_SCB_BYPASS_EN
        chk("byp_same_d", 0, rd_data1, 32'h55);
`else
        chk("byp_same_d", 0, rd_data1, 32'h0);
`endif
        chk("byp_same_p", 0, {31'h0, rd_pend1}, 32'h0);
        @(negedge clk);
        wr_en = 1'b0;
        #1;
        $display("bypass: r9 after edge = %h", rd_data1);
        chk("byp_next_d", 0, rd_data1, 32'h55);
        wr_en = 1'b1; wr_addr = 9; wr_data = 32'h66; iss_en = 1'b1; iss_addr = 9;
        #1;
`ifdef REGFILE_SCB_BYPASS_EN
        chk("byp_iss_d", 0, rd_data1, 32'h66);
        chk("byp_iss_p", 0, {31'h0, rd_pend1}, 32'h1);
`else
        chk("byp_iss_d", 0, rd_data1, 32'h55);
        chk("byp_iss_p", 0, {31'h0, rd_pend1}, 32'h0);
`endif
        @(negedge clk);
        wr_en = 1'b0; iss_en = 1'b0;
        #1;
        chk("byp_iss_next_d", 0, rd_data1, 32'h66);
        chk("byp_iss_next_p", 0, {31'h0, rd_pend1}, 32'h1);

        // Fill r1..r31, mark r4 pending, then bulk clear.
        for (int i = 1; i < 32; i++) begin
            @(negedge clk);
            wr_en = 1'b1; wr_addr = 5'(i); wr_data = 32'h1000_0000 | i;
        end
        @(negedge clk);
        wr_en = 1'b0; iss_en = 1'b1; iss_addr = 4;
        @(negedge clk);
        iss_en = 1'b0; rd_addr1 = 31; rd_addr2 = 4;
        #1;
        chk("fill_r31", 0, rd_data1, 32'h1000_001F);
        chk("fill_r4_p", 0, {31'h0, rd_pend2}, 32'h1);
        rd_addr1 = 3;
        #1;
        chk("fill_r3", 0, rd_data1, 32'h1000_0003);
        clr_req = 1'b1;
        @(negedge clk);
        clr_req = 1'b0;
        for (int c = 1; c <= 34; c++) begin
            #1;
            $display("clear cycle %0d: busy=%0b done=%0b", c, clr_busy, clr_done);
            chk("clr_busy", c, {31'h0, clr_busy}, {31'h0, (c <= 33)});
            chk("clr_done", c, {31'h0, clr_done}, {31'h0, (c == 33)});
            if (c == 5) begin
                wr_en = 1'b1; wr_addr = 3; wr_data = 32'h0000_0BAD;
                iss_en = 1'b1; iss_addr = 3; clr_req = 1'b1;
            end
            if (c == 6) begin
                wr_en = 1'b0; iss_en = 1'b0; clr_req = 1'b0;
            end
            @(negedge clk);
        end
        rd_addr1 = 3;
        #1;
        chk("drop_wr_r3_d", 0, rd_data1, 32'h0);
        chk("drop_wr_r3_p", 0, {31'h0, rd_pend1}, 32'h0);
        check_all_zero("clr");

        // Reset asserted at clear cycle 10 aborts the sweep.
        @(negedge clk);
        wr_en = 1'b1; wr_addr = 20; wr_data = 32'h20;
        @(negedge clk);
        wr_en = 1'b0; iss_en = 1'b1; iss_addr = 21;
        @(negedge clk);
        iss_en = 1'b0; rd_addr1 = 20; rd_addr2 = 21;
        #1;
        chk("pre_abort_r20", 0, rd_data1, 32'h20);
        chk("pre_abort_p21", 0, {31'h0, rd_pend2}, 32'h1);
        clr_req = 1'b1;
        @(negedge clk);
        clr_req = 1'b0;
        repeat (9) @(negedge clk);
        #1;
        chk("mid_busy", 0, {31'h0, clr_busy}, 32'h1);
        rst = 1'b1;
        #1;
        $display("abort: rst at clear cycle 10, busy=%0b r20=%h", clr_busy, rd_data1);
        chk("abort_busy", 0, {31'h0, clr_busy}, 32'h0);
        chk("abort_done", 0, {31'h0, clr_done}, 32'h0);
        chk("abort_r20", 0, rd_data1, 32'h0);
        chk("abort_p21", 0, {31'h0, rd_pend2}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        saw_done = 1'b0;
        repeat (40) begin
            @(negedge clk);
            #1;
            if (clr_done) saw_done = 1'b1;
        end
        chk("abort_no_done", 0, {31'h0, saw_done}, 32'h0);
        chk("abort_idle", 0, {31'h0, clr_busy}, 32'h0);
        check_all_zero("abort");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
